number_dispatch: RTL and testbench
==================================

# number_dispatch

Consumer side of the operand-count selection: samples the user-chosen count (0–5) on a start button press and emits exactly that many fixed-width item pulses, separated by fixed idle gaps, to the downstream actuator/display logic. Provides busy/done status and flags out-of-range counts. Sits between the count-selection block and whatever executes the per-item operation.

## Interface
Parameters:
- MAX_COUNT, 5, largest legal count; larger values are rejected
- CNT_W, 3, width of count input and remaining counter
- PULSE_CYCLES, 4, clk cycles item_pulse stays high per item (≥1)
- GAP_CYCLES, 8, clk cycles of low gap between consecutive pulses (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- number_in  in  CNT_W  selected count, must be stable while start is pressed
- start  in  1  raw push-button, asynchronous to clk
- abort  in  1  synchronous abort, clk domain
- item_pulse  out  1  high PULSE_CYCLES per dispatched item
- remaining  out  CNT_W  items not yet completed
- busy  out  1  high in PULSE or GAP
- done  out  1  one-cycle strobe on normal completion
- err  out  1  sticky flag: last start saw number_in > MAX_COUNT

## Operation
- start passes through a 2-flop synchronizer, then a rising-edge detector (third flop); only one rise event per press.
- States: IDLE, PULSE, GAP, DONE.
- IDLE: on rise event:
  - number_in > MAX_COUNT → err=1, remaining=0, stay IDLE.
  - number_in == 0 → err=0, go DONE (no pulses).
  - else → err=0, remaining=number_in, phase counter=0, go PULSE.
- PULSE: item_pulse=1; after PULSE_CYCLES cycles remaining decrements by 1; if new remaining==0 → DONE, else → GAP.
- GAP: item_pulse=0 for GAP_CYCLES cycles, then → PULSE.
- DONE: done=1 for exactly one cycle → IDLE.
- Rise events outside IDLE are ignored (not queued).
- abort in PULSE or GAP → IDLE next edge, remaining=0, item_pulse=0, no done; err unchanged. abort in IDLE/DONE has no effect. abort and rise event in the same IDLE cycle: rise wins.
- remaining never underflows; decrement only when non-zero.

## Timing
- Reset values: item_pulse=0, remaining=0, busy=0, done=0, err=0, state=IDLE, synchronizer flops=0. Reset mid-operation clears all immediately (asynchronous).
- start high before edge k → rise event during cycle after edge k+1 → state leaves IDLE at edge k+2 (3-edge latency).
- All outputs registered; busy = state∈{PULSE,GAP} decoded from registered state.
- Valid count N≥1: busy high for N·PULSE_CYCLES + (N−1)·GAP_CYCLES cycles; done strobes the cycle immediately after busy falls.
- remaining updates on the same edge item_pulse falls.
- number_in sampled only on the rise-event cycle; later changes ignored.

## Structure
- Package number_pkg: MAX_COUNT, CNT_W, state enum (IDLE/PULSE/GAP/DONE); shared with the count-selection block.
- Sub-module btn_sync_edge: 2-flop synchronizer + edge detector, one-cycle pulse output; reused for other panel buttons.
- Phase counter width = clog2(max(PULSE_CYCLES, GAP_CYCLES)).

## Test plan
- Reset mid-PULSE with number_in=3 → all outputs 0 same cycle, IDLE after release, no done.
- number_in=3, press start → exactly 3 pulses of 4 cycles, gaps of 8, busy 28 cycles, remaining 3→2→1→0, single done.
- number_in=0, press → no item_pulse, busy stays 0, done one cycle at edge k+2.
- number_in=6, press → err=1, no pulses, no done; then number_in=2, press → err=0, 2 pulses.
- number_in=5, second start press during GAP → ignored, exactly 5 pulses total.
- number_in=4, abort asserted in second GAP → IDLE next edge, remaining=0, no done, only 2 pulses seen.

Source files
------------

// File: rtl/number_pkg.sv
// Shared definitions for the operand-count selection and dispatch blocks.
package number_pkg;
  localparam int MAX_COUNT = 5;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw panel button plus a rising-edge detector;
// rise is high for exactly one clk cycle per press.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  // sync_q[0], sync_q[1] synchronize; sync_q[2] holds the previous level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/number_dispatch.sv
// Samples the selected count on a start press and emits that many fixed-width
// item pulses separated by fixed gaps, with busy/done/err status.
module number_dispatch
  import number_pkg::*;
#(
  parameter int MAX_COUNT    = number_pkg::MAX_COUNT,
  parameter int CNT_W        = number_pkg::CNT_W,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] number_in,
  input  logic             start,
  input  logic             abort,
  output logic             item_pulse,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             err,
  output state_e           dbg_state
);
  localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  logic rise;

  btn_sync_edge u_start_sync (
    .clk  (clk),
    .rst  (rst),
    .btn  (start),
    .rise (rise)
  );

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              err_q, err_d;
  logic              item_pulse_q, item_pulse_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        // Start rises are only honoured here; abort has no meaning in IDLE.
        if (rise) begin
          if (32'(number_in) > 32'(MAX_COUNT)) begin
            err_d       = 1'b1;
            remaining_d = '0;
          end else if (number_in == '0) begin
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            err_d       = 1'b0;
            remaining_d = number_in;
            phase_d     = '0;
            state_d     = PULSE;
          end
        end
      end
      PULSE: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
          phase_d     = '0;
        end else if (phase_q == PH_W'(PULSE_CYCLES - 1)) begin
          phase_d = '0;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          state_d = (remaining_q <= CNT_W'(1)) ? DONE : GAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
          phase_d     = '0;
        end else if (phase_q == PH_W'(GAP_CYCLES - 1)) begin
          phase_d = '0;
          state_d = PULSE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    item_pulse_d = (state_d == PULSE);
    busy_d       = (state_d == PULSE) || (state_d == GAP);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      remaining_q  <= '0;
      err_q        <= 1'b0;
      item_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      remaining_q  <= remaining_d;
      err_q        <= err_d;
      item_pulse_q <= item_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign item_pulse = item_pulse_q;
  assign remaining  = remaining_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_number_dispatch.sv
// Scoreboard bench for number_dispatch: drivers push expected dispatch records,
// a negedge monitor rebuilds records from the outputs and compares them.
module tb_number_dispatch;
  import number_pkg::*;

  localparam int P  = 4;
  localparam int G  = 8;
  localparam int CW = 3;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] number_in;
  logic          item_pulse;
  logic [CW-1:0] remaining;
  logic          busy;
  logic          done;
  logic          err;
  state_e        dbg_state;

  number_dispatch #(
    .MAX_COUNT    (5),
    .CNT_W        (CW),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .number_in  (number_in),
    .start      (start),
    .abort      (abort),
    .item_pulse (item_pulse),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  // Record: {done_seen, start_remaining[2:0], pulses[3:0], busy_len[7:0]}
  logic [W-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  model_err = 1'b0;

  function automatic logic [W-1:0] mk(bit d, int n, int p, int len);
    return {d, 3'(n), 4'(p), 8'(len)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  bit prev_busy = 1'b0, prev_item = 1'b0, prev_done = 1'b0, in_txn = 1'b0;
  int mon_len, mon_pulses, mon_rem0, mon_pw, mon_gw;

  task automatic pop_compare(logic [W-1:0] rec);
    if (exp_q.size() == 0) begin
      check("unexpected_txn", 32'(rec), 32'hFFFF_FFFF);
    end else begin
      check("txn_record", 32'(rec), 32'(exp_q.pop_front()));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_txn    = 1'b0;
      prev_busy = 1'b0;
      prev_item = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("pulse_implies_busy", 32'(item_pulse && !busy), 32'd0);
      check("done_one_cycle", 32'(done && prev_done), 32'd0);
      if (busy && !prev_busy) begin
        in_txn     = 1'b1;
        mon_len    = 0;
        mon_pulses = 0;
        mon_rem0   = int'(remaining);
        mon_pw     = 0;
        mon_gw     = 0;
      end
      if (in_txn && prev_item && !item_pulse) begin
        check("pulse_width", 32'(mon_pw), 32'(P));
        mon_pulses++;
        check("remaining_after_pulse", 32'(remaining), 32'(mon_rem0 - mon_pulses));
        mon_pw = 0;
        mon_gw = 0;
      end
      if (in_txn && !prev_item && item_pulse && mon_pulses > 0) begin
        check("gap_width", 32'(mon_gw), 32'(G));
        mon_gw = 0;
      end
      if (busy) mon_len++;
      if (item_pulse) mon_pw++;
      if (busy && !item_pulse) mon_gw++;
      if (in_txn && prev_busy && !busy) begin
        pop_compare(mk(done, mon_rem0, mon_pulses, mon_len));
        if (!done) check("remaining_after_abort", 32'(remaining), 32'd0);
        in_txn = 1'b0;
      end else if (done && !prev_busy) begin
        pop_compare(mk(1'b1, int'(remaining), 0, 0));
      end
      prev_busy = busy;
      prev_item = item_pulse;
      prev_done = done;
    end
  end

  // Driver tasks
  task automatic press(int n, bit abort_on_rise);
    @(negedge clk);
    number_in = CW'(n);
    start     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (abort_on_rise) abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (4) @(negedge clk);
    while ((busy || done) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(t >= 2000), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_falls(int a);
    int  falls = 0;
    int  t = 0;
    bit  pv = item_pulse;
    while (falls < a && t < 1000) begin
      @(negedge clk);
      if (pv && !item_pulse) falls++;
      pv = item_pulse;
      t++;
    end
    check("fall_timeout", 32'(t >= 1000), 32'd0);
  endtask

  function automatic void model_press(int n, bit aborted, int a, int j);
    if (n > MAX_COUNT) begin
      model_err = 1'b1;
    end else begin
      model_err = 1'b0;
      if (n == 0) exp_q.push_back(mk(1'b1, 0, 0, 0));
      else if (aborted) exp_q.push_back(mk(1'b0, n, a, a * P + (a - 1) * G + j + 1));
      else exp_q.push_back(mk(1'b1, n, n, n * P + (n - 1) * G));
    end
  endfunction

  task automatic run_normal(int n, bit abort_on_rise);
    model_press(n, 1'b0, 0, 0);
    press(n, abort_on_rise);
    number_in = CW'($urandom_range(0, 7));
    wait_idle();
    check("err_flag", 32'(err), 32'(model_err));
  endtask

  task automatic run_abort(int n, int a, int j);
    model_press(n, 1'b1, a, j);
    press(n, 1'b0);
    wait_falls(a);
    repeat (j) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    check("err_after_abort", 32'(err), 32'(model_err));
  endtask

  task automatic run_repress(int n);
    model_press(n, 1'b0, 0, 0);
    press(n, 1'b0);
    wait_falls(1);
    press(n, 1'b0);
    wait_idle();
    check("err_flag", 32'(err), 32'(model_err));
  endtask

  task automatic run_reset_mid(int n);
    int t = 0;
    press(n, 1'b0);
    wait_falls(1);
    while (!item_pulse && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("second_pulse_timeout", 32'(t >= 100), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_item_pulse", 32'(item_pulse), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    model_err = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    wait_idle();
    check("state_after_reset", 32'(dbg_state), 32'(IDLE));
  endtask

  // Main sequence
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    number_in = '0;
    repeat (3) @(negedge clk);
    check("reset_item_pulse", 32'(item_pulse), 32'd0);
    check("reset_remaining", 32'(remaining), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_reset_mid(3);
    run_normal(3, 1'b0);
    run_normal(0, 1'b0);
    run_normal(6, 1'b0);
    run_normal(2, 1'b0);
    run_repress(5);
    run_abort(4, 2, int'($urandom_range(0, G - 1)));

    // abort while IDLE does nothing
    abort = 1'b1;
    repeat (5) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_state", 32'(dbg_state), 32'(IDLE));

    run_normal(4, 1'b1);
    run_normal(7, 1'b0);
    run_normal(1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int n;
      int mode;
      n    = int'($urandom_range(0, 7));
      mode = int'($urandom_range(0, 2));
      if (mode == 1 && n >= 2 && n <= MAX_COUNT) begin
        run_abort(n, int'($urandom_range(1, n - 1)), int'($urandom_range(0, G - 1)));
      end else if (mode == 2 && n >= 2 && n <= MAX_COUNT) begin
        run_repress(n);
      end else begin
        run_normal(n, 1'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
